// File: rtl/ov7670_sccb_config.sv
// ---------------------------------------------------------------------------
// ov7670_sccb_config
//
// Power-on / on-demand bring-up sequencer for the OV7670 camera. After an
// accepted start it pulses the camera hardware reset, waits for power-up,
// and then walks a register table. Each table entry becomes one SCCB
// 3-phase write {DEV_ADDR, reg_addr, value} on SCL/SDA.
//
// Table entry encoding (rom_data = {reg_addr, value}):
//   16'hFFFF  end of table
//   16'hFFF0  insert a DELAY_CYCLES pause
//   other     register write
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   start        single-cycle request to run the full sequence (IDLE only)
//   busy         high from the accepted start until done/error
//   done         level, set on normal completion, cleared by the next start
//   error        level, ACK failure (ACK checking builds only)
//   rom_addr     table index
//   rom_data     table entry, valid one cycle after rom_addr changes
//   cam_reset_n  camera hardware reset, active low
//   sccb_scl     SCCB clock, push-pull
//   sccb_sda_oe  1 = drive SDA low, 0 = release (external pull-up)
//   sccb_sda_in  SDA pin readback
//
// Build option: define SCCB_ACK_CHECK_EN to sample the ninth (ACK) bit of
// every byte. A NACK finishes the current STOP, raises error and returns
// to IDLE with rom_addr left on the failing entry. Without the macro the
// ninth bit is don't-care, error stays 0 and sccb_sda_in is unused.
// ---------------------------------------------------------------------------
module ov7670_sccb_config #(
  parameter int         CLK_DIV      = 125,
  parameter logic [7:0] DEV_ADDR     = 8'h42,
  parameter int         NUM_REGS     = 128,
  parameter int         RESET_CYCLES = 50000,
  parameter int         PWRUP_CYCLES = 150000,
  parameter int         DELAY_CYCLES = 500000,
  parameter int         GAP_CYCLES   = 500,
  localparam int        AW           = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  output logic          cam_reset_n,
  output logic          sccb_scl,
  output logic          sccb_sda_oe,
  input  logic          sccb_sda_in
);

  localparam int MAX_RP = (RESET_CYCLES > PWRUP_CYCLES) ? RESET_CYCLES : PWRUP_CYCLES;
  localparam int MAX_DG = (DELAY_CYCLES > GAP_CYCLES) ? DELAY_CYCLES : GAP_CYCLES;
  localparam int MAXC   = (MAX_RP > MAX_DG) ? MAX_RP : MAX_DG;
  localparam int CW     = $clog2(MAXC + 1);
  localparam int QW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_HWRST, S_PWRUP, S_FETCH, S_START,
    S_BIT, S_STOP, S_GAP, S_DELAY, S_FIN
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;          // cycle counter for timed states
  logic [QW-1:0] qdiv, qdiv_n;        // clk count inside one quarter-bit
  logic [1:0]    qtr, qtr_n;          // quarter index inside a bus phase
  logic [3:0]    bitpos, bitpos_n;    // 0..7 data, 8 = ACK slot
  logic [1:0]    byte_idx, byte_n;    // 0..2 within the 3-phase write
  logic [23:0]   shreg, shreg_n;      // remaining bits, MSB goes out next
  logic [AW-1:0] rom_addr_n;
  logic          busy_n, done_n, error_n, nack, nack_n;
  logic          crn_n, scl_n, oe_n;
  logic          q_end, advance;

  assign q_end = (qdiv == QW'(CLK_DIV - 1));

`ifndef SCCB_ACK_CHECK_EN
  logic unused_sda;
  assign unused_sda = sccb_sda_in;
`endif

  always_comb begin
    // NOTE: every value written here gets a default first, so no path can infer a latch.
    state_n    = state;
    cnt_n      = cnt;
    qdiv_n     = qdiv;
    qtr_n      = qtr;
    bitpos_n   = bitpos;
    byte_n     = byte_idx;
    shreg_n    = shreg;
    rom_addr_n = rom_addr;
    busy_n     = busy;
    done_n     = done;
    error_n    = error;
    nack_n     = nack;
    advance    = 1'b0;

    // Quarter-bit timebase runs only while a bus phase is in progress.
    if (state == S_START || state == S_BIT || state == S_STOP) begin
      qdiv_n = q_end ? '0 : qdiv + QW'(1);
      if (q_end) qtr_n = qtr + 2'd1;
    end

    case (state)
      S_IDLE: if (start) begin
        busy_n  = 1'b1;
        done_n  = 1'b0;
        error_n = 1'b0;
        cnt_n   = '0;
        state_n = S_HWRST;
      end
      S_HWRST: if (cnt == CW'(RESET_CYCLES - 1)) begin
        cnt_n   = '0;
        state_n = S_PWRUP;
      end else cnt_n = cnt + CW'(1);
      S_PWRUP: if (cnt == CW'(PWRUP_CYCLES - 1)) begin
        cnt_n      = '0;
        rom_addr_n = '0;
        state_n    = S_FETCH;
      end else cnt_n = cnt + CW'(1);
      // First cycle presents rom_addr, second captures rom_data.
      S_FETCH: if (cnt == '0) cnt_n = CW'(1);
      else begin
        cnt_n = '0;
        if (rom_data == 16'hFFFF)      state_n = S_FIN;
        else if (rom_data == 16'hFFF0) state_n = S_DELAY;
        else begin
          shreg_n  = {DEV_ADDR, rom_data};
          qdiv_n   = '0;
          qtr_n    = 2'd0;
          bitpos_n = 4'd0;
          byte_n   = 2'd0;
          nack_n   = 1'b0;
          state_n  = S_START;
        end
      end
      S_START: if (q_end && qtr == 2'd1) begin
        qtr_n   = 2'd0;
        state_n = S_BIT;
      end
      S_BIT: if (q_end) begin
`ifdef SCCB_ACK_CHECK_EN
        if (qtr == 2'd2 && bitpos == 4'd8) nack_n = nack | sccb_sda_in;
`endif
        if (qtr == 2'd3) begin
          if (bitpos == 4'd8) begin
            bitpos_n = 4'd0;
            if (byte_idx == 2'd2) state_n = S_STOP;
            else                  byte_n  = byte_idx + 2'd1;
          end else begin
            bitpos_n = bitpos + 4'd1;
            shreg_n  = {shreg[22:0], 1'b0};
          end
        end
      end
      S_STOP: if (q_end && qtr == 2'd3) begin
        cnt_n   = '0;
        state_n = S_GAP;
`ifdef SCCB_ACK_CHECK_EN
        if (nack) begin
          busy_n  = 1'b0;
          error_n = 1'b1;
          state_n = S_IDLE;
        end
`endif
      end
      S_GAP: if (cnt == CW'(GAP_CYCLES - 1)) advance = 1'b1;
      else cnt_n = cnt + CW'(1);
      // The two FETCH cycles of the delay entry count toward its pause, so
      // the entry as a whole occupies DELAY_CYCLES.
      S_DELAY: if (cnt == CW'(DELAY_CYCLES - 3)) advance = 1'b1;
      else cnt_n = cnt + CW'(1);
      S_FIN: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // The last table slot ends the run without wrapping rom_addr.
    if (advance) begin
      cnt_n = '0;
      if (rom_addr == AW'(NUM_REGS - 1)) state_n = S_FIN;
      else begin
        rom_addr_n = rom_addr + AW'(1);
        state_n    = S_FETCH;
      end
    end

    if (state_n == S_FIN) begin
      busy_n = 1'b0;
      done_n = 1'b1;
    end

    // Pin levels derive from the next state so they are registered and change
    // exactly on quarter boundaries.
    crn_n = (state_n != S_HWRST);
    scl_n = 1'b1;
    oe_n  = 1'b0;
    case (state_n)
      S_START: begin
        scl_n = (qtr_n == 2'd0);
        oe_n  = 1'b1;
      end
      S_BIT: begin
        scl_n = (qtr_n == 2'd1) || (qtr_n == 2'd2);
        oe_n  = (bitpos_n == 4'd8) ? 1'b0 : ~shreg_n[23];
      end
      S_STOP: begin
        scl_n = (qtr_n != 2'd0);
        oe_n  = (qtr_n == 2'd0) || (qtr_n == 2'd1);
      end
      default: ;
    endcase
  end

  // NOTE: reset is asynchronous, so the bus is released immediately even mid-transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      qdiv        <= '0;
      qtr         <= 2'd0;
      bitpos      <= 4'd0;
      byte_idx    <= 2'd0;
      shreg       <= '0;
      rom_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      nack        <= 1'b0;
      cam_reset_n <= 1'b1;
      sccb_scl    <= 1'b1;
      sccb_sda_oe <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state       <= state_n;
      cnt         <= cnt_n;
      qdiv        <= qdiv_n;
      qtr         <= qtr_n;
      bitpos      <= bitpos_n;
      byte_idx    <= byte_n;
      shreg       <= shreg_n;
      rom_addr    <= rom_addr_n;
      busy        <= busy_n;
      done        <= done_n;
      error       <= error_n;
      nack        <= nack_n;
      cam_reset_n <= crn_n;
      sccb_scl    <= scl_n;
      sccb_sda_oe <= oe_n;
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// ---------------------------------------------------------------------------
// tb_ov7670_sccb_config
//
// Stimulus pushes the expected SCCB writes and cam_reset_n pulse widths into
// queues; a bus monitor decodes START/bits/STOP and the reset pulse from the
// pins and pops/compares as they appear. Timing and status are checked
// directly by the stimulus. Builds with or without SCCB_ACK_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_ov7670_sccb_config;

  localparam int CLK_DIV      = 4;
  localparam int NUM_REGS     = 4;
  localparam int RESET_CYCLES = 10;
  localparam int PWRUP_CYCLES = 20;
  localparam int DELAY_CYCLES = 100;
  localparam int GAP_CYCLES   = 16;
  localparam int TXN_CYCLES   = (2 + 108 + 4) * CLK_DIV + GAP_CYCLES;
  localparam int BUDGET       = 20000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [1:0]  rom_addr;
  logic [15:0] rom_data;
  logic        cam_reset_n, sccb_scl, sccb_sda_oe, sccb_sda_in;
  logic        nack_en = 1'b0;
  logic [15:0] rom [4];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Scoreboard queues and monitor observations.
  logic [26:0] exp_txn[$];
  int          exp_rst_low[$];
  int          start_cycs[$];
  int          rel_cycs[$];
  int          mon_nb = 0;
  logic [26:0] mon_bits = '0;
  logic        in_txn = 1'b0;
  logic        prev_scl = 1'b1, prev_oe = 1'b0, prev_crn = 1'b1;
  int          low_start = 0;

  ov7670_sccb_config #(
    .CLK_DIV(CLK_DIV), .DEV_ADDR(8'h42), .NUM_REGS(NUM_REGS),
    .RESET_CYCLES(RESET_CYCLES), .PWRUP_CYCLES(PWRUP_CYCLES),
    .DELAY_CYCLES(DELAY_CYCLES), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .error(error), .rom_addr(rom_addr), .rom_data(rom_data),
    .cam_reset_n(cam_reset_n), .sccb_scl(sccb_scl),
    .sccb_sda_oe(sccb_sda_oe), .sccb_sda_in(sccb_sda_in)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Slave model: acknowledges every byte, except a NACK on the second ACK
  // slot (27 recorded bits -> mon_nb 18 after its rising SCL) of entry 2.
  assign sccb_sda_in = ~sccb_sda_oe & nack_en & (rom_addr == 2'd2) & (mon_nb == 18);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [26:0] mk_txn(input logic [7:0] ra, input logic [7:0] val);
    return {8'h42, 1'b1, ra, 1'b1, val, 1'b1};
  endfunction

  // Bus monitor.
  always @(negedge clk) begin
    if (reset) begin
      in_txn = 1'b0;
      mon_nb = 0;
    end else begin
      if (sccb_scl && prev_scl && sccb_sda_oe && !prev_oe) begin
        in_txn   = 1'b1;
        mon_nb   = 0;
        mon_bits = '0;
        start_cycs.push_back(cyc);
      end else if (in_txn && sccb_scl && !prev_scl) begin
        if (mon_nb < 27) mon_bits = {mon_bits[25:0], ~sccb_sda_oe};
        mon_nb++;
      end else if (in_txn && sccb_scl && prev_scl && !sccb_sda_oe && prev_oe) begin
        in_txn = 1'b0;
        rel_cycs.push_back(cyc);
        // 27 data/ACK clocks plus the rising SCL of the STOP phase.
        check("scl_pulses", 32'(mon_nb), 32'd28);
        check("txn_pending", 32'(exp_txn.size() != 0), 32'd1);
        if (exp_txn.size() != 0) check("txn_bits", 32'(mon_bits), 32'(exp_txn.pop_front()));
      end
      if (!cam_reset_n && prev_crn) low_start = cyc;
      if (cam_reset_n && !prev_crn) begin
        check("rst_pulse_pending", 32'(exp_rst_low.size() != 0), 32'd1);
        if (exp_rst_low.size() != 0) check("rst_low_cycles", 32'(cyc - low_start), 32'(exp_rst_low.pop_front()));
      end
    end
    prev_scl = sccb_scl;
    prev_oe  = sccb_sda_oe;
    prev_crn = cam_reset_n;
  end

  task automatic load_rom(input logic [15:0] a, b, c, d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    start_cycs.delete();
    rel_cycs.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int fin_cyc);
    int n = 0;
    while (busy !== 1'b0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, 32'(n < BUDGET), 32'd1);
    fin_cyc = cyc;
  endtask

  task automatic wait_starts(input string name, input int count);
    int n = 0;
    while (start_cycs.size() < count && n < BUDGET) begin
      @(posedge clk);
      n++;
    end
    check({name, "_start_timeout"}, 32'(n < BUDGET), 32'd1);
  endtask

  task automatic check_drained(input string name);
    check({name, "_txn_left"}, 32'(exp_txn.size()), 32'd0);
    check({name, "_rst_left"}, 32'(exp_rst_low.size()), 32'd0);
  endtask

  initial begin
    int fin, s0, s1, r0, n;
    load_rom(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_cam_reset_n", 32'(cam_reset_n), 32'd1);
    check("rst_scl", 32'(sccb_scl), 32'd1);
    check("rst_sda_oe", 32'(sccb_sda_oe), 32'd0);
    #2 reset = 1'b0;

    // Single write 0x42 0x12 0x80, then terminator.
    load_rom(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
    exp_rst_low.push_back(RESET_CYCLES);
    exp_txn.push_back(mk_txn(8'h12, 8'h80));
    pulse_start();
    wait_idle("t1", fin);
    s0 = (start_cycs.size() > 0) ? start_cycs[0] : -1;
    check("t1_txn_len", 32'(fin - s0), 32'(TXN_CYCLES + 2));
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_rom_addr", 32'(rom_addr), 32'd1);
    check_drained("t1");

    // Delay entry between two writes.
    load_rom(16'h1100, 16'hFFF0, 16'h1101, 16'hFFFF);
    exp_rst_low.push_back(RESET_CYCLES);
    exp_txn.push_back(mk_txn(8'h11, 8'h00));
    exp_txn.push_back(mk_txn(8'h11, 8'h01));
    pulse_start();
    wait_idle("t2", fin);
    r0 = (rel_cycs.size() > 0) ? rel_cycs[0] : -1;
    s1 = (start_cycs.size() > 1) ? start_cycs[1] : -1;
    // SDA release is 2 quarters before STOP ends.
    check("t2_delay_gap", 32'(s1 - r0), 32'(2 * CLK_DIV + GAP_CYCLES + DELAY_CYCLES + 2));
    check("t2_done", 32'(done), 32'd1);
    check("t2_rom_addr", 32'(rom_addr), 32'd3);
    check_drained("t2");

    // No terminator: table end stops after NUM_REGS writes; start while busy ignored.
    load_rom(16'h1201, 16'h1302, 16'h1403, 16'h1504);
    exp_rst_low.push_back(RESET_CYCLES);
    exp_txn.push_back(mk_txn(8'h12, 8'h01));
    exp_txn.push_back(mk_txn(8'h13, 8'h02));
    exp_txn.push_back(mk_txn(8'h14, 8'h03));
    exp_txn.push_back(mk_txn(8'h15, 8'h04));
    pulse_start();
    check("t3_done_cleared", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    pulse_start();
    check("t3_hwrst_busy_start", 32'(cam_reset_n), 32'd0);
    wait_starts("t3", 2);
    pulse_start();
    check("t3_busy_start_addr", 32'(rom_addr), 32'd1);
    check("t3_busy_start_crn", 32'(cam_reset_n), 32'd1);
    check("t3_busy_start_busy", 32'(busy), 32'd1);
    wait_idle("t3", fin);
    s0 = (start_cycs.size() > 0) ? start_cycs[0] : -1;
    s1 = (start_cycs.size() > 1) ? start_cycs[1] : -1;
    check("t3_start_to_start", 32'(s1 - s0), 32'(TXN_CYCLES + 2));
    check("t3_num_writes", 32'(start_cycs.size()), 32'd4);
    check("t3_done", 32'(done), 32'd1);
    check("t3_rom_addr", 32'(rom_addr), 32'd3);
    check_drained("t3");

    // Reset during bit 5 of the second byte, then a full replay.
    load_rom(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
    exp_rst_low.push_back(RESET_CYCLES);
    pulse_start();
    n = 0;
    while (!(mon_nb == 15 && sccb_scl == 1'b0) && n < BUDGET) begin
      @(posedge clk);
      n++;
    end
    check("t4_bit_timeout", 32'(n < BUDGET), 32'd1);
    @(negedge clk);
    check("t4_pre_oe", 32'(sccb_sda_oe), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t4_scl", 32'(sccb_scl), 32'd1);
    check("t4_sda_oe", 32'(sccb_sda_oe), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    check_drained("t4_abort");
    exp_rst_low.push_back(RESET_CYCLES);
    exp_txn.push_back(mk_txn(8'h12, 8'h80));
    pulse_start();
    check("t4_replay_hwrst", 32'(cam_reset_n), 32'd0);
    wait_idle("t4", fin);
    check("t4_done", 32'(done), 32'd1);
    check("t4_rom_addr", 32'(rom_addr), 32'd1);
    check_drained("t4");

    // NACK on the second ACK slot of entry 2.
    load_rom(16'h1100, 16'h1101, 16'h1102, 16'hFFFF);
    nack_en = 1'b1;
    exp_rst_low.push_back(RESET_CYCLES);
    exp_txn.push_back(mk_txn(8'h11, 8'h00));
    exp_txn.push_back(mk_txn(8'h11, 8'h01));
    exp_txn.push_back(mk_txn(8'h11, 8'h02));
    pulse_start();
    wait_idle("t5", fin);
    nack_en = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
    check("t5_error", 32'(error), 32'd1);
    check("t5_done", 32'(done), 32'd0);
    check("t5_rom_addr", 32'(rom_addr), 32'd2);
`else
    check("t5_error", 32'(error), 32'd0);
    check("t5_done", 32'(done), 32'd1);
    check("t5_rom_addr", 32'(rom_addr), 32'd3);
`endif
    check_drained("t5");

    // Next start clears status and runs normally.
    load_rom(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
    exp_rst_low.push_back(RESET_CYCLES);
    exp_txn.push_back(mk_txn(8'h12, 8'h80));
    pulse_start();
    check("t6_error_cleared", 32'(error), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    wait_idle("t6", fin);
    check("t6_done", 32'(done), 32'd1);
    check_drained("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
